// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin owner of the shared vga_adapter plot port.
// Ports: clk/reset; per-engine req, x_in/y_in/colour_in/plot_in (packed);
//   grant/owner/busy status; registered x/y/colour/plot; timeout pulse.
module vga_plot_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_HOLD = 40000,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] x_in,
  input  logic [7*NUM_REQ-1:0] y_in,
  input  logic [8*NUM_REQ-1:0] colour_in,
  input  logic [NUM_REQ-1:0]   plot_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic [2:0]           owner,
  output logic                 busy,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [7:0]           colour,
  output logic                 plot,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state, state_n;
  logic [2:0]         ptr, ptr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_REQ-1:0] lock, lock_n;

  logic [NUM_REQ-1:0] grant_n;
  logic [2:0]         owner_n;
  logic               busy_n;
  logic [7:0]         x_n, colour_n;
  logic [6:0]         y_n;
  logic               plot_n, timeout_n;

  logic [NUM_REQ-1:0] elig, pick_oh;
  logic [2:0]         pick, pick_lo, pick_hi;
  logic               hi_hit, found;

  logic [7:0]         sel_x, sel_c;
  logic [6:0]         sel_y;
  logic               own_req, own_plot;
  logic               expire;
  logic [2:0]         ptr_adv;

  // Lowest eligible index at/after ptr wins; else wrap to lowest overall.
  always_comb begin
    elig    = req & ~lock;
    found   = |elig;
    pick_lo = '0;
    pick_hi = '0;
    hi_hit  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick_lo = 3'(i);
        if (3'(i) >= ptr) begin
          pick_hi = 3'(i);
          hi_hit  = 1'b1;
        end
      end
    end
    pick = hi_hit ? pick_hi : pick_lo;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_oh[i] = (3'(i) == pick);
    end
  end

  // grant is one-hot of owner, so it doubles as the AND-OR mux select.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x = sel_x | x_in[8*i +: 8];
        sel_y = sel_y | y_in[7*i +: 7];
        sel_c = sel_c | colour_in[8*i +: 8];
      end
    end
    own_req  = |(req & grant);
    own_plot = |(plot_in & grant);
    expire   = (MAX_HOLD != 0) && (cnt == LAST);
    ptr_adv  = (owner == 3'(NUM_REQ - 1)) ? 3'd0 : owner + 3'd1;
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    lock_n    = lock & req;
    grant_n   = grant;
    owner_n   = owner;
    busy_n    = busy;
    x_n       = x;
    y_n       = y;
    colour_n  = colour;
    plot_n    = plot;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n = pick_oh;
          owner_n = pick;
          busy_n  = 1'b1;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        x_n      = sel_x;
        y_n      = sel_y;
        colour_n = sel_c;
        plot_n   = own_plot;
        cnt_n    = cnt + 1'b1;
        // A req drop wins over a same-edge watchdog expiry.
        if (!own_req) begin
          grant_n = '0;
          busy_n  = 1'b0;
          plot_n  = 1'b0;
          ptr_n   = ptr_adv;
          state_n = RELEASE;
        end else if (expire) begin
          grant_n   = '0;
          busy_n    = 1'b0;
          plot_n    = 1'b0;
          timeout_n = 1'b1;
          lock_n    = lock_n | grant;
          ptr_n     = ptr_adv;
          state_n   = RELEASE;
        end
      end
      RELEASE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      lock    <= '0;
      grant   <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      lock    <= lock_n;
      grant   <= grant_n;
      owner   <= owner_n;
      busy    <= busy_n;
      x       <= x_n;
      y       <= y_n;
      colour  <= colour_n;
      plot    <= plot_n;
      timeout <= timeout_n;
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed + random bench for vga_plot_arbiter.
// Compares every cycle against a job-level reference model.
module tb_vga_plot_arbiter;

  localparam int N    = 3;
  localparam int MAXH = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, plot_in;
  logic [8*N-1:0] x_in, colour_in;
  logic [7*N-1:0] y_in;
  logic [N-1:0]   grant;
  logic [2:0]     owner;
  logic           busy, plot, timeout;
  logic [7:0]     x, colour;
  logic [6:0]     y;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_plot_arbiter #(
    .NUM_REQ (N),
    .MAX_HOLD(MAXH),
    .CNT_W   (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .x_in     (x_in),
    .y_in     (y_in),
    .colour_in(colour_in),
    .plot_in  (plot_in),
    .grant    (grant),
    .owner    (owner),
    .busy     (busy),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .timeout  (timeout)
  );

  // Reference model: who owns the port, how long, and who is locked out.
  bit         m_busy;
  int         m_own;
  int         m_held;
  bit         m_dead;
  bit [N-1:0] m_lock;
  int         m_ptr;
  logic [7:0] m_x, m_c;
  logic [6:0] m_y;
  bit         m_plot, m_to;

  task automatic m_reset();
    m_busy = 0; m_own = 0; m_held = 0; m_dead = 0;
    m_lock = '0; m_ptr = 0;
    m_x = '0; m_y = '0; m_c = '0;
    m_plot = 0; m_to = 0;
  endtask

  task automatic model_edge();
    bit [N-1:0] nl;
    bit f;
    int idx;
    nl   = m_lock & req;
    m_to = 0;
    if (m_busy) begin
      m_x    = x_in[8*m_own +: 8];
      m_y    = y_in[7*m_own +: 7];
      m_c    = colour_in[8*m_own +: 8];
      m_plot = plot_in[m_own];
      m_held++;
      if (!req[m_own]) begin
        m_busy = 0; m_plot = 0; m_dead = 1;
        m_ptr  = (m_own + 1) % N;
      end else if (m_held == MAXH) begin
        m_busy = 0; m_plot = 0; m_dead = 1; m_to = 1;
        nl[m_own] = 1'b1;
        m_ptr  = (m_own + 1) % N;
      end
    end else if (m_dead) begin
      m_dead = 0;
    end else begin
      f = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!f && req[idx] && !m_lock[idx]) begin
          f = 1; m_own = idx;
        end
      end
      if (f) begin
        m_busy = 1; m_held = 0;
      end
    end
    m_lock = nl;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = '0;
    if (m_busy) eg[m_own] = 1'b1;
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("owner", 32'(owner), 32'(m_own));
    chk("x", 32'(x), 32'(m_x));
    chk("y", 32'(y), 32'(m_y));
    chk("colour", 32'(colour), 32'(m_c));
    chk("plot", 32'(plot), 32'(m_plot));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("plot_idle", 32'(plot & ~busy), 32'd0);
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_grant(input logic [N-1:0] m,
                            input int budget,
                            input string tag);
    int n;
    n = 0;
    while (grant !== m && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 32'(grant), 32'(m));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int order[$];
    int held, gap, hi, tcnt, idx;
    logic p2;
    reset = 1'b1; req = '0; plot_in = '0;
    x_in = '0; y_in = '0; colour_in = '0;
    m_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;

    // single engine
    req = 3'b010;
    cycle();
    chk("single_grant", 32'(grant), 32'(3'b010));
    x_in[15:8] = 8'd25; y_in[13:7] = 7'd60; plot_in = 3'b010;
    cycle();
    chk("single_plot", 32'(plot), 32'd1);
    chk("single_x", 32'(x), 32'd25);
    chk("single_y", 32'(y), 32'd60);
    plot_in = '0; req = '0;
    cycle();
    chk("single_drop", 32'(grant), 32'd0);
    repeat (2) cycle();

    // reset mid-grant
    req = 3'b111; plot_in = 3'b111;
    cycle();
    cycle();
    #2 reset = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    plot_in = '0;
    cycle();
    chk("rst_first", 32'(grant), 32'(3'b001));

    // round robin: each owner drops req after 4 cycles
    order.push_back(0);
    held = 1; gap = 0;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      req = (held == 4) ? (3'b111 & ~grant) : 3'b111;
      cycle();
      if (grant != '0) begin
        if (held == 0) begin
          idx = 0;
          for (int i = 0; i < N; i++) if (grant[i]) idx = i;
          order.push_back(idx);
          chk("rr_gap", 32'(gap), 32'd2);
        end
        held++;
        gap = 0;
      end else begin
        held = 0;
        gap++;
      end
    end
    chk("rr_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      chk("rr_0", 32'(order[0]), 32'd0);
      chk("rr_1", 32'(order[1]), 32'd1);
      chk("rr_2", 32'(order[2]), 32'd2);
      chk("rr_3", 32'(order[3]), 32'd0);
    end
    req = '0;
    repeat (3) cycle();

    // non-owner isolation
    req = 3'b100;
    wait_grant(3'b100, 5, "iso_grant");
    for (int c = 0; c < 6; c++) begin
      x_in[7:0]   = 8'd99;
      x_in[23:16] = 8'($urandom_range(0, 98));
      p2 = 1'($urandom);
      plot_in = {p2, 1'b0, 1'(c % 2 == 0)};
      cycle();
      chk("iso_x99", 32'(x == 8'd99), 32'd0);
      chk("iso_plot", 32'(plot), 32'(p2));
    end
    plot_in = '0; req = '0;
    repeat (3) cycle();

    // watchdog
    req = 3'b011;
    cycle();
    chk("wd_grant0", 32'(grant), 32'(3'b001));
    hi = 1; tcnt = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (timeout) tcnt++;
      if (grant[0]) hi++;
      else break;
    end
    chk("wd_hold", 32'(hi), 32'd8);
    chk("wd_pulse", 32'(tcnt), 32'd1);
    wait_grant(3'b010, 5, "wd_next1");
    cycle();
    cycle();
    req = 3'b001;
    for (int c = 0; c < 7; c++) begin
      cycle();
      if (timeout) tcnt++;
      chk("wd_lock", 32'(grant[0]), 32'd0);
    end
    chk("wd_pulse_once", 32'(tcnt), 32'd1);
    req = '0;
    cycle();
    req = 3'b001;
    wait_grant(3'b001, 5, "wd_regrant");

    // tie: req drops on the expiry edge
    tcnt = 0;
    for (int c = 0; c < 7; c++) begin
      cycle();
      if (timeout) tcnt++;
    end
    chk("tie_still", 32'(grant), 32'(3'b001));
    req = '0;
    cycle();
    if (timeout) tcnt++;
    chk("tie_drop", 32'(grant), 32'd0);
    cycle();
    if (timeout) tcnt++;
    chk("tie_no_to", 32'(tcnt), 32'd0);
    repeat (2) cycle();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      plot_in   = N'($urandom);
      x_in      = (8*N)'($urandom);
      y_in      = (7*N)'($urandom);
      colour_in = (8*N)'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
